// File: rtl/life_window_pkg.sv
// Shared definitions for the Game of Life neighbourhood datapath: the window FSM
// states and the neighbour bit positions used by the counter and cell-update logic.
package life_window_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_STREAM,
        ST_FLUSH
    } state_e;

    localparam int NB_NW    = 0;
    localparam int NB_N     = 1;
    localparam int NB_NE    = 2;
    localparam int NB_W     = 3;
    localparam int NB_E     = 4;
    localparam int NB_SW    = 5;
    localparam int NB_S     = 6;
    localparam int NB_SE    = 7;
    localparam int NB_COUNT = 8;

endpackage

// File: rtl/life_edge_mask.sv
// Clears the neighbour bits that fall outside the board for the cell at (x, y).
module life_edge_mask
    import life_window_pkg::*;
#(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int XW = $clog2(W),
    parameter int YW = $clog2(H)
) (
    input  logic [NB_COUNT-1:0] taps,
    input  logic [XW-1:0]       x,
    input  logic [YW-1:0]       y,
    output logic [NB_COUNT-1:0] masked
);

    localparam logic [XW-1:0] X_MAX = XW'(W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

    always_comb begin
        masked = taps;
        if (x == '0) begin
            masked[NB_NW] = 1'b0;
            masked[NB_W]  = 1'b0;
            masked[NB_SW] = 1'b0;
        end
        if (x == X_MAX) begin
            masked[NB_NE] = 1'b0;
            masked[NB_E]  = 1'b0;
            masked[NB_SE] = 1'b0;
        end
        if (y == '0) begin
            masked[NB_NW] = 1'b0;
            masked[NB_N]  = 1'b0;
            masked[NB_NE] = 1'b0;
        end
        if (y == Y_MAX) begin
            masked[NB_SW] = 1'b0;
            masked[NB_S]  = 1'b0;
            masked[NB_SE] = 1'b0;
        end
    end

endmodule

// File: rtl/life_window.sv
// Streaming 3x3 neighbourhood extractor: row-major cells in, one registered
// centre + 8-neighbour beat out per cell, with zero-padding at the board edges.
module life_window
    import life_window_pkg::*;
#(
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_cell,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_center,
    output logic [NB_COUNT-1:0]   out_neighbors,
    output logic [$clog2(W)-1:0]  out_x,
    output logic [$clog2(H)-1:0]  out_y,
    output logic                  out_last
);

    localparam int XW     = $clog2(W);
    localparam int YW     = $clog2(H);
    localparam int SR_N   = 2 * W + 3;
    localparam int P_LAST = W * H + W;
    localparam int PW     = $clog2(P_LAST + 1);

    localparam logic [PW-1:0] P_FILL_END = PW'(W + 1);
    localparam logic [PW-1:0] P_FLUSH    = PW'(W * H);
    localparam logic [PW-1:0] P_END      = PW'(P_LAST);
    localparam logic [XW-1:0] X_MAX      = XW'(W - 1);
    localparam logic [YW-1:0] Y_MAX      = YW'(H - 1);

    state_e              state_q, state_d;
    logic [PW-1:0]       p_q, p_d;
    logic [SR_N-1:0]     sr_q, sr_d;
    logic [XW-1:0]       ex_q, ex_d;
    logic [YW-1:0]       ey_q, ey_d;
    logic                started_q, started_d;
    logic                out_valid_q, out_valid_d;
    logic                out_center_q, out_center_d;
    logic [NB_COUNT-1:0] out_nb_q, out_nb_d;
    logic [XW-1:0]       out_x_q, out_x_d;
    logic [YW-1:0]       out_y_q, out_y_d;
    logic                out_last_q, out_last_d;

    logic                slot_free, in_ready_c, adv, emit, sample;
    logic [SR_N-1:0]     sr_shift;
    logic [NB_COUNT-1:0] taps, masked;

    // In FLUSH the window is fed zeros so the last rows see an empty row below.
    assign sample   = (state_q == ST_FLUSH) ? 1'b0 : in_cell;
    assign sr_shift = {sr_q[SR_N-2:0], sample};

    always_comb begin
        taps         = '0;
        taps[NB_NW]  = sr_shift[2*W+2];
        taps[NB_N]   = sr_shift[2*W+1];
        taps[NB_NE]  = sr_shift[2*W];
        taps[NB_W]   = sr_shift[W+2];
        taps[NB_E]   = sr_shift[W];
        taps[NB_SW]  = sr_shift[2];
        taps[NB_S]   = sr_shift[1];
        taps[NB_SE]  = sr_shift[0];
    end

    life_edge_mask #(.W(W), .H(H), .XW(XW), .YW(YW)) u_edge_mask (
        .taps   (taps),
        .x      (ex_q),
        .y      (ey_q),
        .masked (masked)
    );

    always_comb begin
        slot_free  = !out_valid_q || out_ready;
        in_ready_c = started_q && (state_q != ST_FLUSH) && slot_free;
        adv        = (state_q == ST_FLUSH) ? slot_free : (in_valid && in_ready_c);
        emit       = adv && (p_q >= P_FILL_END);

        state_d      = state_q;
        p_d          = p_q;
        sr_d         = sr_q;
        ex_d         = ex_q;
        ey_d         = ey_q;
        started_d    = 1'b1;
        out_valid_d  = out_valid_q && !out_ready;
        out_center_d = out_center_q;
        out_nb_d     = out_nb_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_last_d   = out_last_q;

        if (adv) begin
            sr_d = sr_shift;
            p_d  = (p_q == P_END) ? '0 : p_q + PW'(1);
            if (p_d < P_FILL_END) begin
                state_d = ST_FILL;
            end else if (p_d < P_FLUSH) begin
                state_d = ST_STREAM;
            end else begin
                state_d = ST_FLUSH;
            end
        end

        if (emit) begin
            out_valid_d  = 1'b1;
            out_center_d = sr_shift[W+1];
            out_nb_d     = masked;
            out_x_d      = ex_q;
            out_y_d      = ey_q;
            out_last_d   = (ex_q == X_MAX) && (ey_q == Y_MAX);
            if (ex_q == X_MAX) begin
                ex_d = '0;
                ey_d = (ey_q == Y_MAX) ? '0 : ey_q + YW'(1);
            end else begin
                ex_d = ex_q + XW'(1);
            end
            if (p_q == P_END) begin
                ex_d = '0;
                ey_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            p_q          <= '0;
            sr_q         <= '0;
            ex_q         <= '0;
            ey_q         <= '0;
            started_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_center_q <= 1'b0;
            out_nb_q     <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            sr_q         <= sr_d;
            ex_q         <= ex_d;
            ey_q         <= ey_d;
            started_q    <= started_d;
            out_valid_q  <= out_valid_d;
            out_center_q <= out_center_d;
            out_nb_q     <= out_nb_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_last_q   <= out_last_d;
        end
    end

    assign in_ready      = in_ready_c;
    assign out_valid     = out_valid_q;
    assign out_center    = out_center_q;
    assign out_neighbors = out_nb_q;
    assign out_x         = out_x_q;
    assign out_y         = out_y_q;
    assign out_last      = out_last_q;

endmodule

// File: tb/tb_life_window.sv
// Directed bench for life_window: a 3x3 all-ones instance and a 4x4 instance
// checked against a board model, with stalls, back-to-back frames and reset.
module tb_life_window;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_in_cell, a_out_valid, a_out_ready;
    logic       a_out_center, a_out_last;
    logic [7:0] a_out_nb;
    logic [1:0] a_out_x, a_out_y;

    logic       b_in_valid, b_in_ready, b_in_cell, b_out_valid, b_out_ready;
    logic       b_out_center, b_out_last;
    logic [7:0] b_out_nb;
    logic [1:0] b_out_x, b_out_y;

    life_window #(.W(3), .H(3)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_cell(a_in_cell),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_center(a_out_center), .out_neighbors(a_out_nb),
        .out_x(a_out_x), .out_y(a_out_y), .out_last(a_out_last)
    );

    life_window #(.W(4), .H(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_cell(b_in_cell),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_center(b_out_center), .out_neighbors(b_out_nb),
        .out_x(b_out_x), .out_y(b_out_y), .out_last(b_out_last)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] boards [4];
    logic [7:0]  cap_nb [16];
    logic        cap_c  [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference neighbourhood of cell (x,y) on a 4x4 board, bit order NW,N,NE,W,E,SW,S,SE.
    function automatic logic [7:0] model_nb(input logic [15:0] b, input int x, input int y);
        int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        logic [7:0] r;
        int nx, ny;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            nx = x + dx[k];
            ny = y + dy[k];
            if (nx >= 0 && nx < 4 && ny >= 0 && ny < 4) r[k] = b[ny*4+nx];
        end
        return r;
    endfunction

    task automatic run_b(input int nfr, input int pct, input bit check_gap);
        int sent = 0;
        int got = 0;
        int gap = 0;
        int fr, i;
        bit prev_stall = 1'b0;
        logic [13:0] prev_o = '0;
        logic [13:0] cur_o;
        for (int cyc = 0; cyc < 3000 && got < nfr * 16; cyc++) begin
            @(negedge clk);
            b_out_ready = ($urandom_range(99) < pct);
            if (sent < nfr * 16) begin
                b_in_valid = 1'b1;
                b_in_cell  = boards[sent/16][sent%16];
            end else begin
                b_in_valid = 1'b0;
                b_in_cell  = 1'b0;
            end
            #1;
            cur_o = {b_out_center, b_out_nb, b_out_x, b_out_y, b_out_last};
            if (prev_stall) begin
                check("b_hold_valid", b_out_valid, 1);
                check("b_hold_data", cur_o, prev_o);
            end
            if (b_out_valid && b_out_ready) begin
                fr = got / 16;
                i  = got % 16;
                check("b_nb", b_out_nb, model_nb(boards[fr], i % 4, i / 4));
                check("b_center", b_out_center, boards[fr][i]);
                check("b_x", b_out_x, i % 4);
                check("b_y", b_out_y, i / 4);
                check("b_last", b_out_last, (i == 15));
                cap_nb[i] = b_out_nb;
                cap_c[i]  = b_out_center;
                got++;
            end
            if (check_gap && sent > 0 && sent % 16 == 0 && sent < nfr * 16) begin
                if (!b_in_ready) gap++;
                else begin
                    check("b_gap", gap, 5);
                    gap = 0;
                end
            end
            if (b_in_valid && b_in_ready) sent++;
            prev_stall = b_out_valid && !b_out_ready;
            prev_o     = cur_o;
        end
        check("b_beats", got, nfr * 16);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("b_no_extra", b_out_valid, 0);
        end
    endtask

    initial begin
        int a_cnt [9];
        int a_exp [9] = '{3, 5, 3, 5, 8, 5, 3, 5, 3};
        logic a_last [9];
        logic a_cen [9];
        logic [3:0] a_pos [9];
        logic [7:0] a_mid_nb;
        int sent, got, n;

        rst_n = 1'b0;
        a_in_valid = 0; a_in_cell = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_cell = 0; b_out_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_outs", {b_out_center, b_out_nb, b_out_x, b_out_y, b_out_last}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_a_in_ready", a_in_ready, 1);
        check("post_rst_b_in_ready", b_in_ready, 1);

        // 3x3 all-ones board
        sent = 0; got = 0; a_mid_nb = '0;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 9; cyc++) begin
            @(negedge clk);
            a_in_valid = (sent < 9);
            a_in_cell  = 1'b1;
            #1;
            if (a_out_valid && a_out_ready) begin
                a_cnt[got]  = $countones(a_out_nb);
                a_last[got] = a_out_last;
                a_cen[got]  = a_out_center;
                a_pos[got]  = {a_out_x, a_out_y};
                if (got == 4) a_mid_nb = a_out_nb;
                got++;
            end
            if (a_in_valid && a_in_ready) sent++;
        end
        a_in_valid = 1'b0;
        check("a_beats", got, 9);
        for (int k = 0; k < 9 && k < got; k++) begin
            check("a_count", a_cnt[k], a_exp[k]);
            check("a_last", a_last[k], (k == 8));
            check("a_center", a_cen[k], 1);
            check("a_pos", a_pos[k], {2'(k % 3), 2'(k / 3)});
        end
        check("a_mid_nb", a_mid_nb, 8'hFF);

        // 4x4 vertical blinker at x=1, y=0..2
        boards[0] = 16'h0222;
        run_b(1, 100, 1'b0);
        check("blink_11_nb", cap_nb[5], 8'h42);
        check("blink_11_c", cap_c[5], 1);
        check("blink_01_nb", cap_nb[4], 8'h94);

        // three random boards with a 50% stalling consumer
        for (int k = 0; k < 3; k++) boards[k] = 16'($urandom);
        run_b(3, 50, 1'b0);

        // back-to-back frames, in_valid held high
        for (int k = 0; k < 3; k++) boards[k] = 16'($urandom);
        run_b(3, 100, 1'b1);

        // reset after 7 cells of a frame
        n = 0;
        b_out_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && n < 7; cyc++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_cell  = 1'b1;
            #1;
            if (b_in_ready) n++;
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        check("mid_pre_valid", b_out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", b_out_valid, 0);
        check("mid_rst_outs", {b_out_center, b_out_nb, b_out_x, b_out_y, b_out_last}, 0);
        check("mid_rst_in_ready", b_in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single live cell at (0,0)
        boards[0] = 16'h0001;
        run_b(1, 100, 1'b0);
        check("corner_10", cap_nb[1], 8'h08);
        check("corner_01", cap_nb[4], 8'h02);
        check("corner_11", cap_nb[5], 8'h01);
        for (int k = 0; k < 16; k++) begin
            if (k != 1 && k != 4 && k != 5) check("corner_zero", cap_nb[k], 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
